// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - RV32I MEM-stage load/store unit with req/gnt/rvalid data bus
package riscv_lsu_pkg;
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        ctrl_t       ctrl;
    } ex_mem_t;
endpackage

module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_valid_i,
    input  ex_mem_t     ex_mem_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic        err_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] cnt;
    logic        err_q;
    logic [31:0] load_data_q;

    logic        rd, wr, mem_op, width_ok, misaligned, accept, reject, tmo;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] rshift;
    logic [31:0] load_fmt;

    logic unused_bits;
    assign unused_bits = ^{ex_mem_i.instr[31:15], ex_mem_i.instr[11:0],
                           ex_mem_i.ctrl.reg_write, ex_mem_i.ctrl.mem_to_reg};

    always_comb begin
        rd     = ex_mem_i.ctrl.mem_read;
        wr     = ex_mem_i.ctrl.mem_write;
        f3     = ex_mem_i.instr[14:12];
        off    = ex_mem_i.alu_result[1:0];
        mem_op = ex_mem_valid_i & (rd | wr);
        case (f3)
            3'b000, 3'b001, 3'b010: width_ok = 1'b1;
            3'b100, 3'b101:         width_ok = rd;
            default:                width_ok = 1'b0;
        endcase
        misaligned = ((f3[1:0] == 2'b01) & off[0]) |
                     ((f3[1:0] == 2'b10) & (off != 2'b00));
        accept = (state == S_IDLE) & mem_op & width_ok & ~(rd & wr) & ~misaligned;
        reject = (state == S_IDLE) & mem_op & ~(width_ok & ~(rd & wr) & ~misaligned);
        case (f3[1:0])
            2'b00:   be_nxt = 4'b0001 << off;
            2'b01:   be_nxt = 4'b0011 << off;
            default: be_nxt = 4'b1111;
        endcase
        if (rd)
            be_nxt = 4'b1111;
        case (f3[1:0])
            2'b00:   wdata_nxt = {4{ex_mem_i.rs2_data[7:0]}};
            2'b01:   wdata_nxt = {2{ex_mem_i.rs2_data[15:0]}};
            default: wdata_nxt = ex_mem_i.rs2_data;
        endcase
    end

    // Lane select uses the offset latched at accept, not the live EX/MEM address.
    always_comb begin
        rshift = dmem_rdata_i >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_fmt = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  load_fmt = {{16{rshift[15]}}, rshift[15:0]};
            3'b100:  load_fmt = {24'b0, rshift[7:0]};
            3'b101:  load_fmt = {16'b0, rshift[15:0]};
            default: load_fmt = dmem_rdata_i;
        endcase
    end

    assign tmo = (TIMEOUT_CYCLES != 0) && (cnt >= TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            cnt         <= '0;
            err_q       <= 1'b0;
            load_data_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q  <= {ex_mem_i.alu_result[31:2], 2'b00};
                        be_q    <= be_nxt;
                        wdata_q <= wdata_nxt;
                        we_q    <= wr;
                        f3_q    <= f3;
                        off_q   <= off;
                        cnt     <= '0;
                        err_q   <= 1'b0;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    cnt <= cnt + 32'd1;
                    if (dmem_gnt_i) begin
                        state <= S_RESP;
                    end else if (tmo) begin
                        err_q       <= 1'b1;
                        load_data_q <= '0;
                        state       <= S_DONE;
                    end
                end
                S_RESP: begin
                    cnt <= cnt + 32'd1;
                    if (dmem_rvalid_i) begin
                        if (!we_q)
                            load_data_q <= load_fmt;
                        state <= S_DONE;
                    end else if (tmo) begin
                        err_q       <= 1'b1;
                        load_data_q <= '0;
                        state       <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign stall_o      = accept | (state == S_REQ) | (state == S_RESP);
    assign done_o       = (state == S_DONE) | reject;
    assign err_o        = ((state == S_DONE) & err_q) | reject;
    assign dmem_req_o   = (state == S_REQ);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign load_data_o  = load_data_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - randomized and directed checks of riscv_lsu against a behavioural model
module tb_riscv_lsu;
    import riscv_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_mem_valid_i = 1'b0;
    ex_mem_t     ex_mem_i = '0;
    logic        stall_o, done_o, err_o, dmem_req_o, dmem_we_o;
    logic [31:0] load_data_o, dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;

    int n_vec = 0;
    int n_err = 0;

    riscv_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_valid_i(ex_mem_valid_i), .ex_mem_i(ex_mem_i),
        .stall_o(stall_o), .done_o(done_o), .load_data_o(load_data_o), .err_o(err_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2);
        logic [31:0] ins;
        ins = $urandom;
        ins[14:12] = f3;
        ex_mem_valid_i            = 1'b1;
        ex_mem_i.instr            = ins;
        ex_mem_i.alu_result       = addr;
        ex_mem_i.rs2_data         = rs2;
        ex_mem_i.ctrl.mem_read    = rd;
        ex_mem_i.ctrl.mem_write   = wr;
        ex_mem_i.ctrl.reg_write   = rd;
        ex_mem_i.ctrl.mem_to_reg  = rd;
    endtask

    task automatic idle(input logic stray_rvalid);
        @(negedge clk);
        ex_mem_valid_i = $urandom_range(0, 1);
        ex_mem_i.ctrl.mem_read  = 1'b0;
        ex_mem_i.ctrl.mem_write = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = stray_rvalid;
        dmem_rdata_i  = $urandom;
        #1;
        check("idle_stall", stall_o, 0);
        check("idle_done", done_o, 0);
        check("idle_req", dmem_req_o, 0);
        dmem_rvalid_i = 1'b0;
    endtask

    // g = REQ cycles without gnt, r = RESP cycles without rvalid
    task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2,
                       input int g, input int r, input logic [31:0] rdata);
        int          size, total, off;
        logic        ok;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_ld;
        longint      v, span;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off  = int'(addr % 4);
        ok = (rd != wr) && ((f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) ||
                            (rd && (f3 == 3'd4 || f3 == 3'd5))) && (addr % size == 0);
        exp_be = '0;
        for (int i = 0; i < size; i++) exp_be[off + i] = 1'b1;
        if (rd) exp_be = 4'hF;
        for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = rs2[8*(j % size) +: 8];
        v = longint'(rdata >> (8 * off));
        if (size < 4) begin
            span = longint'(1) << (8 * size);
            v = v % span;
            if (!f3[2] && v >= span / 2) v = v - span;
        end
        exp_ld = v[31:0];

        @(negedge clk);
        drive_op(rd, wr, f3, addr, rs2);
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        if (!ok) begin
            #1;
            check("rej_done", done_o, 1);
            check("rej_err", err_o, 1);
            check("rej_stall", stall_o, 0);
            check("rej_req", dmem_req_o, 0);
            @(negedge clk);
            ex_mem_valid_i = 1'b0;
            #1;
            check("rej_after_done", done_o, 0);
            check("rej_after_req", dmem_req_o, 0);
            return;
        end
        total = g + r + 3;
        for (int c = 0; c <= total; c++) begin
            if (c > 0) @(negedge clk);
            dmem_gnt_i    = (c == g + 1);
            dmem_rvalid_i = (c == g + r + 2);
            dmem_rdata_i  = (c == g + r + 2) ? rdata : $urandom;
            #1;
            check("stall", stall_o, (c < total) ? 1 : 0);
            check("done", done_o, (c == total) ? 1 : 0);
            check("err", err_o, 0);
            check("req", dmem_req_o, (c >= 1 && c <= g + 1) ? 1 : 0);
            if (c >= 1 && c <= g + 1) begin
                check("addr", dmem_addr_o, addr - (addr % 4));
                check("be", dmem_be_o, exp_be);
                check("we", dmem_we_o, wr);
                if (wr) check("wdata", dmem_wdata_o, exp_wd);
            end
            if (c == total && rd) check("load_data", load_data_o, exp_ld);
        end
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b0;
    endtask

    initial begin
        logic [2:0]  f3r;
        logic [31:0] ar;
        int          kind;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall", stall_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_req", dmem_req_o, 0);
        check("rst_we", dmem_we_o, 0);
        check("rst_addr", dmem_addr_o, 0);
        check("rst_be", dmem_be_o, 0);
        check("rst_wdata", dmem_wdata_o, 0);
        check("rst_load", load_data_o, 0);

        txn(1, 0, 3'b010, 32'h100, 0, 0, 0, 32'hDEADBEEF);
        check("lw_data", load_data_o, 32'hDEADBEEF);
        txn(1, 0, 3'b000, 32'h103, 0, 0, 0, 32'h80123456);
        check("lb_data", load_data_o, 32'hFFFFFF80);
        txn(1, 0, 3'b100, 32'h103, 0, 1, 0, 32'h80123456);
        check("lbu_data", load_data_o, 32'h00000080);
        txn(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 1, 0);
        check("sh_be", dmem_be_o, 4'b1100);
        check("sh_wdata", dmem_wdata_o, 32'hABCDABCD);
        check("sh_addr", dmem_addr_o, 32'h200);
        txn(1, 0, 3'b010, 32'h101, 0, 0, 0, 0);
        txn(1, 0, 3'b011, 32'h100, 0, 0, 0, 0);
        txn(1, 1, 3'b010, 32'h100, 0, 0, 0, 0);
        txn(1, 0, 3'b010, 32'h300, 0, 4, 1, 32'h0BADF00D);
        idle(1'b1);

        @(negedge clk);
        drive_op(1, 0, 3'b010, 32'h40, 0);
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) @(negedge clk);
            dmem_gnt_i = 1'b0;
            dmem_rvalid_i = 1'b0;
            #1;
            check("to_stall", stall_o, (c < 9) ? 1 : 0);
            check("to_req", dmem_req_o, (c >= 1 && c <= 8) ? 1 : 0);
            check("to_done", done_o, (c == 9) ? 1 : 0);
            check("to_err", err_o, (c == 9) ? 1 : 0);
        end
        check("to_load", load_data_o, 0);
        idle(1'b0);

        txn(1, 0, 3'b010, 32'h44, 0, 0, 0, 32'h13579BDF);
        @(negedge clk);
        drive_op(1, 0, 3'b010, 32'h80, 0);
        #1;
        check("rm_accept_stall", stall_o, 1);
        @(negedge clk);
        dmem_gnt_i = 1'b1;
        #1;
        check("rm_req", dmem_req_o, 1);
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        #1;
        check("rm_resp_req", dmem_req_o, 0);
        check("rm_resp_stall", stall_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ex_mem_valid_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'hFFFFFFFF;
        #1;
        check("rm_req_after", dmem_req_o, 0);
        check("rm_stall_after", stall_o, 0);
        check("rm_done_after", done_o, 0);
        check("rm_load_after", load_data_o, 0);
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        #1;
        check("rm_no_done", done_o, 0);

        for (int k = 0; k < 60; k++) begin
            kind = $urandom_range(0, 9);
            f3r = 3'($urandom_range(0, 7));
            ar = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                case (f3r[1:0])
                    2'b01:   ar[0] = 1'b0;
                    2'b10:   ar[1:0] = 2'b00;
                    default: ;
                endcase
            end
            if (kind < 5)
                txn(1, 0, f3r, ar, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
            else if (kind < 8)
                txn(0, 1, f3r, ar, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
            else if (kind == 8)
                txn(1, 1, f3r, ar, $urandom, 0, 0, $urandom);
            else
                idle(1'($urandom_range(0, 1)));
        end
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit for the RV32I pipeline's MEM stage. Consumes the `ex_mem_t` bundle, issues at most one data-memory transaction over a req/gnt/rvalid bus, and formats the returned load data for the MEM/WB register. Holds the pipeline through `stall_o` until the access completes. Reports misaligned, illegal-width and timed-out accesses through `err_o` without side effects on memory.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in REQ plus RESP before the access is abandoned. A value of 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `ex_mem_valid_i`  in  1  EX/MEM register holds a live instruction
- `ex_mem_i`  in  `ex_mem_t`  address in `alu_result`, store data in `rs2_data`, access width in `instr[14:12]`, `ctrl.mem_read`/`ctrl.mem_write`
- `stall_o`  out  1  freeze IF through EX/MEM; the EX/MEM contents must stay stable while this is 1
- `done_o`  out  1  one-cycle pulse: memory op finished; `load_data_o`/`err_o` valid
- `load_data_o`  out  32  sign- or zero-extended load result
- `err_o`  out  1  one-cycle pulse: misaligned, illegal funct3, read+write both set, or timeout
- `dmem_req_o`  out  1  bus request
- `dmem_we_o`  out  1  1 = store
- `dmem_addr_o`  out  32  word address; bits [1:0] are always 0
- `dmem_be_o`  out  4  byte enables
- `dmem_wdata_o`  out  32  lane-replicated store data
- `dmem_gnt_i`  in  1  request accepted
- `dmem_rvalid_i`  in  1  response; exactly one per granted request, stores included
- `dmem_rdata_i`  in  32  read data, valid with `rvalid`

## Operation
- **Memory op** = `ex_mem_valid_i & (mem_read | mem_write)`. Define `off = alu_result[1:0]` and `f3 = instr[14:12]`.
- **Legal accesses**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other `f3`, or `mem_read & mem_write`, is illegal.
- **Misalignment**: halfword access with `off[0] = 1`; word access with `off != 0`.
- **Byte enables**: SB = `4'b0001 << off`; SH = `4'b0011 << off`; SW = `4'b1111`. Loads drive `4'b1111`.
- **Store data**: SB = `{4{rs2[7:0]}}`; SH = `{2{rs2[15:0]}}`; SW = `rs2`.
- **Load data**
  - Select the byte or halfword lane of `rdata` by `off`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
  - Captured into a register on `rvalid`.
- **FSM states**: IDLE, REQ, RESP, DONE.
  - IDLE, legal memory op → latch `addr & ~3`, `be`, `wdata`, `we`, `f3`, `off`; clear the timeout counter; go to REQ.
  - IDLE, illegal or misaligned memory op → pulse `err_o` and `done_o` in that cycle; no bus activity; no stall; stay in IDLE. Pipeline flush/trap handling is outside this block.
  - IDLE, no memory op → stay in IDLE.
  - REQ: `dmem_req_o = 1`; bus outputs come from the latched values and stay stable until `gnt`.
    - `gnt` → go to RESP.
  - RESP: `dmem_req_o = 0`.
    - `rvalid` → capture load data → go to DONE.
    - `rvalid` in the same cycle as `gnt` while in REQ is not allowed by the protocol and is ignored.
  - Timeout: counter increments every cycle in REQ or RESP. When it reaches `TIMEOUT_CYCLES`, set `err_o` pending, set `load_data_o = 0`, drop `req`, and go to DONE.
  - DONE: `done_o = 1`; `err_o = 1` if a timeout occurred; `stall_o = 0`. Go to IDLE next cycle. The pipeline advances on this edge.
- **Stall**: `stall_o = (IDLE & legal memory op) | REQ | RESP`.
- **Stray `rvalid`**: ignored in IDLE and in DONE.

## Timing
- **Reset values**: state IDLE; `stall_o`, `done_o`, `err_o`, `dmem_req_o`, `dmem_we_o` = 0; `dmem_addr_o`, `dmem_be_o`, `dmem_wdata_o`, `load_data_o` = 0.
- **Zero-wait bus**: accept at T0 (stall=1); REQ at T1 with `gnt`; RESP at T2 with `rvalid`; DONE at T3 (`done_o`=1, stall=0). Minimum of 3 stall cycles.
- **Waits**: each cycle without `gnt` or `rvalid` adds one stall cycle.
- **Non-memory instructions**: `stall_o` = 0, `done_o` = 0, zero added latency.
- **Back-to-back memory ops**: the next one is accepted in the IDLE cycle after DONE.
- **Reset mid-op**: state returns to IDLE and `req` drops on the next edge. The outstanding bus response is discarded.
- **`load_data_o`**: holds its value until the next capture or reset.

## Test plan
- LW `addr=0x100`; bus gives `gnt` at T1 and `rvalid` at T2 with `rdata=0xDEADBEEF` → `addr_o=0x100`, `be=1111`, `done_o` at T3, `load_data_o=0xDEADBEEF`, stall high for T0 through T2.
- LB `addr=0x103`, `rdata=0x80xxxxxx` → `load_data_o=0xFFFFFF80`. Same access as LBU → `0x00000080`.
- SH `addr=0x202`, `rs2=0x1234ABCD` → `we=1`, `be=1100`, `wdata=0xABCDABCD`, `addr_o=0x200`.
- LW `addr=0x101` → `err_o` and `done_o` pulse in the same cycle; `req` never asserts; `stall_o`=0. Same for `f3=011`.
- `gnt` withheld for 4 cycles, then `rvalid` 2 cycles after `gnt` → stall high for 8 cycles; bus outputs stable throughout REQ.
- `TIMEOUT_CYCLES=8`, no `gnt` → `err_o` and `done_o` 9 cycles after accept, `load_data_o=0`. Separately, `rst` asserted during RESP → IDLE and `req=0` next cycle; a later `rvalid` produces no `done_o`.
